// File: rtl/hello_msg_sequencer.sv
// Streams a fixed ASCII "Hello World\r\n" message over a valid/ready byte link on each trigger pulse.
// Optional feature HELLO_SEQ_COUNT_EN appends " XX" (hex message counter) before CR/LF.
module hello_msg_sequencer #(
   parameter int GAP_CYCLES = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       i_trigger,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_busy,
   output logic       o_overrun
);

`ifdef HELLO_SEQ_COUNT_EN
   localparam int MSG_LEN = 16;
`else
   localparam int MSG_LEN = 13;
`endif
   localparam int IDX_W = $clog2(MSG_LEN);
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [GAP_W-1:0] gap_cnt;

`ifdef HELLO_SEQ_COUNT_EN
   logic [7:0] msg_cnt;
   logic [7:0] cnt_lat;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   // Byte 0 never depends on the count, so reading cnt_lat before it is latched is harmless.
   function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] i);
      case (i)
         4'd0:    return 8'h48;
         4'd1:    return 8'h65;
         4'd2:    return 8'h6C;
         4'd3:    return 8'h6C;
         4'd4:    return 8'h6F;
         4'd5:    return 8'h20;
         4'd6:    return 8'h57;
         4'd7:    return 8'h6F;
         4'd8:    return 8'h72;
         4'd9:    return 8'h6C;
         4'd10:   return 8'h64;
         4'd11:   return 8'h20;
         4'd12:   return hex_char(cnt_lat[7:4]);
         4'd13:   return hex_char(cnt_lat[3:0]);
         4'd14:   return 8'h0D;
         default: return 8'h0A;
      endcase
   endfunction
`else
   function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] i);
      case (i)
         4'd0:    return 8'h48;
         4'd1:    return 8'h65;
         4'd2:    return 8'h6C;
         4'd3:    return 8'h6C;
         4'd4:    return 8'h6F;
         4'd5:    return 8'h20;
         4'd6:    return 8'h57;
         4'd7:    return 8'h6F;
         4'd8:    return 8'h72;
         4'd9:    return 8'h6C;
         4'd10:   return 8'h64;
         4'd11:   return 8'h0D;
         4'd12:   return 8'h0A;
         default: return 8'h00;
      endcase
   endfunction
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         idx       <= '0;
         gap_cnt   <= '0;
         o_valid   <= 1'b0;
         o_data    <= 8'h00;
         o_busy    <= 1'b0;
         o_overrun <= 1'b0;
`ifdef HELLO_SEQ_COUNT_EN
         msg_cnt   <= 8'h00;
         cnt_lat   <= 8'h00;
`endif
      end else begin
         // A trigger is only accepted from IDLE; any other trigger is an overrun.
         if (i_trigger && (state != IDLE))
            o_overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (i_trigger) begin
                  state   <= SEND;
                  idx     <= '0;
                  o_valid <= 1'b1;
                  o_busy  <= 1'b1;
                  o_data  <= msg_byte('0);
`ifdef HELLO_SEQ_COUNT_EN
                  cnt_lat <= msg_cnt;
`endif
               end
            end

            SEND: begin
               if (i_ready) begin
                  if (idx == LAST_IDX) begin
                     state   <= IDLE;
                     o_valid <= 1'b0;
                     o_busy  <= 1'b0;
`ifdef HELLO_SEQ_COUNT_EN
                     msg_cnt <= msg_cnt + 8'd1;
`endif
                  end else begin
                     idx    <= idx + 1'b1;
                     o_data <= msg_byte(idx + 1'b1);
                     if (GAP_CYCLES > 0) begin
                        state   <= GAP;
                        o_valid <= 1'b0;
                        gap_cnt <= GAP_LOAD;
                     end
                  end
               end
            end

            GAP: begin
               if (gap_cnt == '0) begin
                  state   <= SEND;
                  o_valid <= 1'b1;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end

            default: begin
               state   <= IDLE;
               o_valid <= 1'b0;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hello_msg_sequencer.sv
// Directed bench for hello_msg_sequencer: back-to-back, stalled, gapped, overrun and reset-abort cases.
// Honours HELLO_SEQ_COUNT_EN for the expected message contents.
module tb_hello_msg_sequencer;

`ifdef HELLO_SEQ_COUNT_EN
   localparam int MSG_LEN = 16;
`else
   localparam int MSG_LEN = 13;
`endif
   localparam int GAP = 3;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       trig = 1'b0, ready = 1'b0;
   logic [7:0] data;
   logic       valid, busy, ovr;
   logic       trig_g = 1'b0, ready_g = 1'b0;
   logic [7:0] data_g;
   logic       valid_g, busy_g, ovr_g;

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] cnt0 = 8'h00;
   logic [7:0] cnt_g = 8'h00;

   always #5 clk = ~clk;

   hello_msg_sequencer #(.GAP_CYCLES(0)) dut (
      .clk(clk), .reset_n(reset_n), .i_trigger(trig), .o_data(data),
      .o_valid(valid), .i_ready(ready), .o_busy(busy), .o_overrun(ovr)
   );

   hello_msg_sequencer #(.GAP_CYCLES(GAP)) dut_gap (
      .clk(clk), .reset_n(reset_n), .i_trigger(trig_g), .o_data(data_g),
      .o_valid(valid_g), .i_ready(ready_g), .o_busy(busy_g), .o_overrun(ovr_g)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] hex_ch(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] exp_byte(input int i, input logic [7:0] c);
      case (i)
         0:  return 8'h48;
         1:  return 8'h65;
         2:  return 8'h6C;
         3:  return 8'h6C;
         4:  return 8'h6F;
         5:  return 8'h20;
         6:  return 8'h57;
         7:  return 8'h6F;
         8:  return 8'h72;
         9:  return 8'h6C;
         10: return 8'h64;
`ifdef HELLO_SEQ_COUNT_EN
         11: return 8'h20;
         12: return hex_ch(c[7:4]);
         13: return hex_ch(c[3:0]);
         14: return 8'h0D;
         default: return 8'h0A;
`else
         11: return 8'h0D;
         default: return (c == c) ? 8'h0A : 8'h0A;
`endif
      endcase
   endfunction

   // One full message on the GAP_CYCLES=0 instance with ready tied high; optionally
   // fires extra triggers while byte 5 and the last byte are presented.
   task automatic run_msg(input bit extra_trig);
      trig  = 1'b1;
      ready = 1'b1;
      step();
      trig = 1'b0;
      chk("busy_start", {31'b0, busy}, 1);
      for (int k = 0; k < MSG_LEN; k++) begin
         chk($sformatf("byte%0d", k), {24'b0, data}, {24'b0, exp_byte(k, cnt0)});
         chk($sformatf("valid%0d", k), {31'b0, valid}, 1);
         if (extra_trig && (k == 5 || k == MSG_LEN - 1))
            trig = 1'b1;
         step();
         trig = 1'b0;
      end
      chk("end_valid", {31'b0, valid}, 0);
      chk("end_busy", {31'b0, busy}, 0);
      cnt0 = cnt0 + 8'd1;
   endtask

   initial begin
      int first, last, k;

      // Reset state
      #12;
      chk("rst_valid", {31'b0, valid}, 0);
      chk("rst_data", {24'b0, data}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_ovr", {31'b0, ovr}, 0);
      chk("rst_valid_g", {31'b0, valid_g}, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Ready high while idle does nothing
      ready = 1'b1;
      step();
      step();
      chk("idle_ready_valid", {31'b0, valid}, 0);
      chk("idle_ready_busy", {31'b0, busy}, 0);

      // Back-to-back message
      run_msg(1'b0);
      chk("no_ovr", {31'b0, ovr}, 0);

      // Stall on byte 0 for 5 cycles
      ready = 1'b0;
      trig  = 1'b1;
      step();
      trig = 1'b0;
      for (int s = 0; s < 5; s++) begin
         chk($sformatf("stall_data%0d", s), {24'b0, data}, 32'h48);
         chk($sformatf("stall_valid%0d", s), {31'b0, valid}, 1);
         step();
      end
      ready = 1'b1;
      step();
      chk("after_stall", {24'b0, data}, 32'h65);
      for (int s = 1; s < MSG_LEN; s++) begin
         chk($sformatf("stall_tail%0d", s), {24'b0, data}, {24'b0, exp_byte(s, cnt0)});
         step();
      end
      chk("stall_end_valid", {31'b0, valid}, 0);
      cnt0 = cnt0 + 8'd1;

      // Gapped instance: one valid cycle then GAP idle cycles per byte
      trig_g  = 1'b1;
      ready_g = 1'b1;
      step();
      trig_g = 1'b0;
      first = -1;
      last  = -1;
      k     = 0;
      for (int c = 0; c < 120 && k < MSG_LEN; c++) begin
         if (valid_g) begin
            if (first < 0) first = c;
            chk($sformatf("gap_byte%0d", k), {24'b0, data_g}, {24'b0, exp_byte(k, cnt_g)});
            chk($sformatf("gap_pos%0d", k), c - first, (GAP + 1) * k);
            last = c;
            k++;
         end else if (k > 0) begin
            chk("gap_busy", {31'b0, busy_g}, 1);
         end
         step();
      end
      cnt_g = cnt_g + 8'd1;
      chk("gap_first", first, 0);
      chk("gap_bytes", k, MSG_LEN);
      chk("gap_span", last - first + 1, MSG_LEN + (MSG_LEN - 1) * GAP);
      chk("gap_end_valid", {31'b0, valid_g}, 0);
      chk("gap_end_busy", {31'b0, busy_g}, 0);

      // Overrun triggers at byte 5 and on the last-byte edge
      run_msg(1'b1);
      chk("ovr_set", {31'b0, ovr}, 1);
      step();
      step();
      chk("no_restart_valid", {31'b0, valid}, 0);
      chk("no_restart_busy", {31'b0, busy}, 0);
      chk("ovr_sticky", {31'b0, ovr}, 1);

      // Async reset while byte 7 is presented
      trig = 1'b1;
      step();
      trig = 1'b0;
      for (int s = 0; s < 7; s++) step();
      chk("pre_abort_data", {24'b0, data}, {24'b0, exp_byte(7, cnt0)});
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_valid", {31'b0, valid}, 0);
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_ovr", {31'b0, ovr}, 0);
      cnt0 = 8'h00;
      cnt_g = 8'h00;
      step();
      reset_n = 1'b1;
      step();
      run_msg(1'b0);
      chk("post_reset_ovr", {31'b0, ovr}, 0);

`ifdef HELLO_SEQ_COUNT_EN
      // Counter: messages "01", "02", then wrap back to "00" after 256
      run_msg(1'b0);
      run_msg(1'b0);
      for (int m = 3; m < 256; m++) run_msg(1'b0);
      trig = 1'b1;
      step();
      trig = 1'b0;
      for (int s = 0; s < 12; s++) step();
      chk("wrap_hi", {24'b0, data}, 32'h30);
      step();
      chk("wrap_lo", {24'b0, data}, 32'h30);
      step();
      step();
      step();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hello_msg_sequencer.md
Name: hello_msg_sequencer

Overview:
Downstream consumer of the one-second enable pulse in the UART "hello world" design. On each trigger pulse it streams a fixed ASCII message, one byte at a time, to the UART transmitter over a valid/ready byte interface. The message is held in an internal constant ROM. The block can optionally insert idle gaps between bytes and flags triggers that arrive while a message is still being sent.

Parameters:
GAP_CYCLES, 0, number of cycles o_valid is held low after each accepted byte before the next byte is presented (0 = back-to-back).

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset_n  input  1  asynchronous, active-low reset.
i_trigger  input  1  single-cycle start pulse from the enable generator.
o_data  output  8  current message byte; valid only while o_valid=1.
o_valid  output  1  byte on o_data is available to the UART transmitter.
i_ready  input  1  UART transmitter accepts the byte; a transfer occurs on a rising edge where o_valid=1 and i_ready=1.
o_busy  output  1  high from the first cycle after an accepted trigger until the cycle after the last byte is accepted.
o_overrun  output  1  sticky flag: a trigger arrived while o_busy=1; cleared only by reset.

Behaviour:
- Reset (reset_n=0, asynchronous): state IDLE, index 0, gap counter 0, o_valid=0, o_data=8'h00, o_busy=0, o_overrun=0. The message counter (feature on) resets to 0.
- Reset asserted mid-message: the block aborts immediately. No partial-message resume after release. The next trigger starts again from byte 0.
- Base message, 13 bytes: "Hello World" followed by CR (0x0D) and LF (0x0A). Byte 0 = 0x48, byte 12 = 0x0A.
- States:
  - IDLE: o_valid=0. When i_trigger=1, go to SEND with index=0. o_valid=1 and o_data=byte 0 appear in the following cycle (1-cycle latency).
  - SEND: o_valid=1. o_data=ROM[index], held stable while i_ready=0 (no retraction, no data change).
    - On transfer, not the last byte: index+1. Go to GAP if GAP_CYCLES>0, otherwise stay in SEND with the next byte presented in the next cycle.
    - On transfer of the last byte: go to IDLE. o_valid=0 and o_busy=0 in the next cycle.
  - GAP: o_valid=0 for exactly GAP_CYCLES cycles, then SEND.
    - No gap is inserted after the last byte.
- o_busy=1 in SEND and GAP, and 0 in IDLE.
- i_trigger in SEND or GAP is ignored and sets o_overrun=1. This includes a trigger coinciding with the last-byte transfer edge.
- i_trigger while in IDLE never sets o_overrun.
- Index width: $clog2(message length). The index never exceeds length-1 and does not wrap during a message.
- i_ready=1 while o_valid=0 has no effect.

Optional Feature:
Macro HELLO_SEQ_COUNT_EN.
- Defined: message is 16 bytes: "Hello World", space (0x20), two uppercase ASCII hex digits of an 8-bit message counter (high nibble first), then CR, LF.
  - The counter value is latched at trigger acceptance, so it stays stable for the whole message.
  - The counter increments by 1 after the last-byte transfer and wraps 0xFF -> 0x00.
  - Ignored (overrun) triggers do not increment the counter.
- Undefined: 13-byte base message. No counter logic is synthesized.

Test Plan:
- Reset, then i_trigger pulse with i_ready tied 1, GAP_CYCLES=0 -> o_valid rises 1 cycle after trigger. 13 consecutive bytes 48 65 6C 6C 6F 20 57 6F 72 6C 64 0D 0A, then o_valid=0 and o_busy=0.
- i_ready held 0 for 5 cycles while byte 0 is presented -> o_data stays 0x48 and o_valid stays 1 for all 5 cycles. Byte 1 (0x65) appears the cycle after i_ready=1.
- GAP_CYCLES=3, i_ready=1 -> each byte is valid for 1 cycle, followed by 3 cycles with o_valid=0. Total 13+12*3=49 cycles from first valid to last transfer.
- Trigger at byte 5, and again on the last-byte transfer edge -> message completes unaltered, o_overrun=1 and stays 1, no second message is started. Reset clears o_overrun to 0.
- reset_n pulsed low during byte 7 -> o_valid=0 immediately (asynchronously). The next trigger restarts at 0x48.
- HELLO_SEQ_COUNT_EN defined, three triggers spaced past message end -> bytes 12-13 are "00", "01", "02". After 256 messages the count returns to "00".
